// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer: FSM state encoding and counter sizing.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

    // Gap lengths go up to 255 cycles.
    localparam int unsigned GAP_CNT_W = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle of the serializer; master is the word source, slave is the serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_active;
    logic             word_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_active, word_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_active, word_done
    );
endinterface

// File: rtl/bit_serializer_cnt.sv
// Clearable up-counter with a compare flag raised while the count equals TERM.
module bit_serializer_cnt #(
    parameter int unsigned CW   = 3,
    parameter int unsigned TERM = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic inc,
    output logic hit_c
);
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign hit_c = (count == CW'(TERM));
endmodule

// File: rtl/bit_serializer.sv
// Word-to-bitstream serializer feeding the sequence detector; valid/ready in, one bit per clk out.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input logic             clk,
    input logic             rstn,
    bit_serializer_if.slave bus
);
    localparam int unsigned BIT_CW   = cnt_width(WIDTH);
    localparam int unsigned GAP_TERM = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             ser_out_q, ser_out_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             accept_c;
    logic             bit_clr_c, bit_inc_c, bit_hit_c;
    logic             gap_clr_c, gap_inc_c, gap_hit_c;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    // Bit position: flag marks the next-to-last bit so word_done/in_ready can be registered.
    bit_serializer_cnt #(.CW(BIT_CW), .TERM(WIDTH - 2)) u_bit_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (bit_clr_c),
        .inc   (bit_inc_c),
        .hit_c (bit_hit_c)
    );

    bit_serializer_cnt #(.CW(GAP_CNT_W), .TERM(GAP_TERM)) u_gap_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (gap_clr_c),
        .inc   (gap_inc_c),
        .hit_c (gap_hit_c)
    );

    // Next state and next registered outputs; ready_q only opens on IDLE or a gapless last bit.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        ser_out_d = IDLE_LEVEL;
        active_d  = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b0;
        bit_clr_c = 1'b0;
        bit_inc_c = 1'b0;
        gap_clr_c = 1'b0;
        gap_inc_c = 1'b0;
        accept_c  = bus.in_valid && ready_q;

        if (accept_c) begin
            state_d   = ST_SHIFT;
            sreg_d    = advance(bus.in_data);
            ser_out_d = head(bus.in_data);
            active_d  = 1'b1;
            bit_clr_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ready_d = 1'b1;
                ST_SHIFT: begin
                    if (!done_q) begin
                        bit_inc_c = 1'b1;
                        sreg_d    = advance(sreg_q);
                        ser_out_d = head(sreg_q);
                        active_d  = 1'b1;
                        done_d    = bit_hit_c;
                        ready_d   = bit_hit_c && (GAP_CYCLES == 0);
                    end else if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_clr_c = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_hit_c) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        gap_inc_c = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            ser_out_q <= IDLE_LEVEL;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            ser_out_q <= ser_out_d;
            active_q  <= active_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_active = active_q;
    assign bus.word_done  = done_q;
endmodule
